sw_debounce_pio: RTL and testbench

SW_DEBOUNCE_PIO -- requirements
Module: sw_debounce_pio

---
 rtl/sw_debounce_pio.sv | 165 ++++++++++++++++
 tb/tb_sw_debounce_pio.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_pio.sv
// sw_debounce_pio
//   Debounced switch input port with an Avalon-MM slave register interface.
//   Each raw switch bit is synchronised, then debounced by a per-bit counter:
//   the debounced level only follows the synchronised level after it has
//   disagreed for DEBOUNCE_CYCLES consecutive clocks. Debounced transitions
//   in the selected direction are latched in EDGE_CAPTURE. A level interrupt
//   is raised when a captured edge is unmasked.
//
//   Register map (word address):
//     0 DATA          read-only, debounced levels
//     1 IRQ_MASK      read/write
//     2 EDGE_CAPTURE  read, write-1-to-clear
//     3 EDGE_SEL      read/write, per bit 0 = rising, 1 = falling
//   Bits above WIDTH read as 0 and ignore writes.
//
// Ports
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     word address of the register
//   chipselect  slave select, qualifies read and write
//   read        read strobe, data returned one clock later on readdata
//   write       write strobe, takes effect on the same clock edge
//   writedata   write data
//   readdata    registered read data, 0 when no read was issued
//   SW_in       raw asynchronous switch levels
//   irq         active-high level interrupt
//
// Bus handshake: the slave is always ready. A transfer happens on every
// rising edge where chipselect is high together with read or write; a read
// answers on readdata after exactly one edge and readdata is 0 otherwise.

module sw_debounce_pio #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] SW_in,
    output logic             irq
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_level;
    logic [CNT_W-1:0] cnt [WIDTH];

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] sel_q;

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] wr_val;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      rd_mux;

    // Write-data bits above WIDTH are intentionally discarded.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata};

    assign wr_en      = chipselect & write;
    assign rd_en      = chipselect & read;
    assign wr_val     = writedata[WIDTH-1:0];
    assign sync_level = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; nothing downstream looks at SW_in directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= SW_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // A bit is accepted on the clock its counter already shows
    // DEBOUNCE_CYCLES-1 mismatched clocks and it is still mismatched.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync_level[i] != data_q[i]) && (cnt[i] == CNT_MAX);
        end
    end

    assign rise     = accept & sync_level;
    assign fall     = accept & ~sync_level;
    assign edge_hit = (rise & ~sel_q) | (fall & sel_q);
    assign clr      = (wr_en && address == 2'd2) ? wr_val : '0;

    // Any agreement restarts the count, so glitches never accumulate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((sync_level[i] == data_q[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Registers. A new edge wins over a simultaneous clear of the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            mask_q <= '0;
            cap_q  <= '0;
            sel_q  <= '0;
        end else begin
            data_q <= data_q ^ accept;
            cap_q  <= (cap_q & ~clr) | edge_hit;
            if (wr_en && address == 2'd1) begin
                mask_q <= wr_val;
            end
            if (wr_en && address == 2'd3) begin
                sel_q <= wr_val;
            end
        end
    end

    // Read mux sees the pre-write register values of the current edge.
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = data_q;
            2'd1:    rd_mux[WIDTH-1:0] = mask_q;
            2'd2:    rd_mux[WIDTH-1:0] = cap_q;
            default: rd_mux[WIDTH-1:0] = sel_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_en ? rd_mux : '0;
        end
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_sw_debounce_pio.sv
// Testbench for sw_debounce_pio. The main instance uses WIDTH=10,
// DEBOUNCE_CYCLES=8, SYNC_STAGES=2; two register-only instances cover the
// WIDTH=32 and WIDTH=1 builds. A sliding-window reference model predicts
// every read response, which a separate monitor pops and compares.

module tb_sw_debounce_pio;

    localparam int W = 10;
    localparam int D = 8;
    localparam int S = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bus / pins ----------------
    logic [1:0]   address = '0;
    logic         cs = 1'b0;
    logic         cs32 = 1'b0;
    logic         cs1 = 1'b0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  writedata = '0;
    logic [W-1:0] sw = '0;
    logic [31:0]  sw32 = '0;
    logic [0:0]   sw1 = '0;
    logic [31:0]  rdata;
    logic [31:0]  rdata32;
    logic [31:0]  rdata1;
    logic         irq;
    logic         irq32;
    logic         irq1;

    sw_debounce_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs),
        .read(read), .write(write), .writedata(writedata), .readdata(rdata),
        .SW_in(sw), .irq(irq)
    );

    sw_debounce_pio #(.WIDTH(32), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut_w32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32),
        .read(read), .write(write), .writedata(writedata), .readdata(rdata32),
        .SW_in(sw32), .irq(irq32)
    );

    sw_debounce_pio #(.WIDTH(1), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut_w1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
        .read(read), .write(write), .writedata(writedata), .readdata(rdata1),
        .SW_in(sw1), .irq(irq1)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp32_q[$];
    logic [31:0] exp1_q[$];
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // The debounced level of a bit flips to L on an edge when the raw input
    // sampled on the D edges ending SYNC_STAGES edges earlier was L every
    // time and the debounced level was not L.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_data, m_mask, m_cap, m_sel;
    logic         m_irq;
    logic         rd_seen, rd32_seen, rd1_seen;
    logic [31:0]  a32_mask, a32_sel;
    logic         a1_mask, a1_sel;

    task automatic reset_model();
        m_data = '0; m_mask = '0; m_cap = '0; m_sel = '0; m_irq = 1'b0;
        rd_seen = 1'b0; rd32_seen = 1'b0; rd1_seen = 1'b0;
        a32_mask = '0; a32_sel = '0; a1_mask = 1'b0; a1_sel = 1'b0;
        hist.delete();
        repeat (S + D) hist.push_back('0);
    endtask

    function automatic logic [31:0] main_view(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_data);
            2'd1:    return 32'(m_mask);
            2'd2:    return 32'(m_cap);
            default: return 32'(m_sel);
        endcase
    endfunction

    task automatic step_model();
        logic [W-1:0] rise, fall, ev, clr;
        bit all1, all0;
        if (cs && read) exp_q.push_back(main_view(address));
        if (cs32 && read)
            exp32_q.push_back(address == 2'd1 ? a32_mask : (address == 2'd3 ? a32_sel : 32'h0));
        if (cs1 && read)
            exp1_q.push_back(address == 2'd1 ? 32'(a1_mask) : (address == 2'd3 ? 32'(a1_sel) : 32'h0));
        rd_seen = cs && read;
        rd32_seen = cs32 && read;
        rd1_seen = cs1 && read;

        hist.push_back(sw);
        void'(hist.pop_front());
        for (int i = 0; i < W; i++) begin
            all1 = 1'b1;
            all0 = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (hist[j][i]) all0 = 1'b0;
                else all1 = 1'b0;
            end
            rise[i] = !m_data[i] && all1;
            fall[i] = m_data[i] && all0;
        end
        ev  = (rise & ~m_sel) | (fall & m_sel);
        clr = (cs && write && address == 2'd2) ? writedata[W-1:0] : '0;
        m_cap = (m_cap & ~clr) | ev;
        if (cs && write && address == 2'd1) m_mask = writedata[W-1:0];
        if (cs && write && address == 2'd3) m_sel = writedata[W-1:0];
        m_data = m_data ^ (rise | fall);
        m_irq = |(m_cap & m_mask);

        if (cs32 && write && address == 2'd1) a32_mask = writedata;
        if (cs32 && write && address == 2'd3) a32_sel = writedata;
        if (cs1 && write && address == 2'd1) a1_mask = writedata[0];
        if (cs1 && write && address == 2'd3) a1_sel = writedata[0];
    endtask

    initial begin
        reset_model();
        forever begin
            @(posedge clk);
            if (!reset_n) reset_model();
            else step_model();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rd_seen) begin
                if (exp_q.size() == 0) check("rd_underflow", 32'd1, 32'd0);
                else check("readdata", rdata, exp_q.pop_front());
            end
            if (rd32_seen) begin
                if (exp32_q.size() == 0) check("rd32_underflow", 32'd1, 32'd0);
                else check("readdata_w32", rdata32, exp32_q.pop_front());
            end
            if (rd1_seen) begin
                if (exp1_q.size() == 0) check("rd1_underflow", 32'd1, 32'd0);
                else check("readdata_w1", rdata1, exp1_q.pop_front());
            end
            if (reset_n) check("irq", 32'(irq), 32'(m_irq));
        end
    end

    // ---------------- driver ----------------
    // which: bit0 main instance, bit1 WIDTH=32 instance, bit2 WIDTH=1 instance.
    // Called at a negedge, returns at the next negedge.
    task automatic bus_op(input logic [2:0] which, input logic [1:0] a,
                          input logic [31:0] d, input logic rd, input logic wr);
        address = a; writedata = d; read = rd; write = wr;
        cs = which[0]; cs32 = which[1]; cs1 = which[2];
        @(negedge clk);
        read = 1'b0; write = 1'b0; cs = 1'b0; cs32 = 1'b0; cs1 = 1'b0;
    endtask

    task automatic random_bus_cycle();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 3) bus_op(3'b001, 2'($urandom_range(0, 3)), 32'h0, 1'b1, 1'b0);
        else if (r <= 5) bus_op(3'b001, 2'($urandom_range(0, 3)), $urandom, 1'b0, 1'b1);
        else if (r == 6) bus_op(3'b001, 2'($urandom_range(0, 3)), $urandom, 1'b1, 1'b1);
        else @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_readdata", rdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_readdata_w32", rdata32, 32'h0);
        bus_op(3'b001, 2'd0, 32'h0, 1'b1, 1'b0);
        check("reset_read_held0", rdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Clean rise on bit 3, DATA polled every clock.
        sw[3] = 1'b1;
        repeat (14) bus_op(3'b001, 2'd0, 32'h0, 1'b1, 1'b0);
        bus_op(3'b001, 2'd0, 32'h0, 1'b1, 1'b0);
        check("data_bit3", rdata, 32'h008);
        bus_op(3'b001, 2'd2, 32'h3FF, 1'b0, 1'b1);

        // Five-clock glitch on bit 0 must leave no trace.
        sw[0] = 1'b1;
        repeat (5) @(negedge clk);
        sw[0] = 1'b0;
        for (int k = 0; k < 16; k++) bus_op(3'b001, 2'(k % 2 == 0 ? 0 : 2), 32'h0, 1'b1, 1'b0);
        bus_op(3'b001, 2'd0, 32'h0, 1'b1, 1'b0);
        check("glitch_data", rdata, 32'h008);
        bus_op(3'b001, 2'd2, 32'h0, 1'b1, 1'b0);
        check("glitch_cap", rdata, 32'h000);

        // Rising capture on bit 0 with interrupt, then clear.
        bus_op(3'b001, 2'd1, 32'h001, 1'b0, 1'b1);
        bus_op(3'b001, 2'd3, 32'h000, 1'b0, 1'b1);
        sw[0] = 1'b1;
        repeat (12) @(negedge clk);
        check("irq_rise0", 32'(irq), 32'h1);
        bus_op(3'b001, 2'd2, 32'h0, 1'b1, 1'b0);
        check("cap_rise0", rdata, 32'h001);
        bus_op(3'b001, 2'd2, 32'h001, 1'b0, 1'b1);
        check("irq_cleared", 32'(irq), 32'h0);

        // Falling-edge select on bit 5; clear lands on the capture clock.
        bus_op(3'b001, 2'd3, 32'h020, 1'b0, 1'b1);
        bus_op(3'b001, 2'd1, 32'h021, 1'b0, 1'b1);
        sw[5] = 1'b1;
        repeat (12) @(negedge clk);
        bus_op(3'b001, 2'd2, 32'h0, 1'b1, 1'b0);
        check("cap_no_rise5", rdata, 32'h000);
        sw[5] = 1'b0;
        repeat (9) @(negedge clk);
        bus_op(3'b001, 2'd2, 32'h020, 1'b0, 1'b1);
        bus_op(3'b001, 2'd2, 32'h0, 1'b1, 1'b0);
        check("cap_fall5_wins", rdata, 32'h020);
        check("irq_fall5", 32'(irq), 32'h1);
        bus_op(3'b001, 2'd2, 32'h020, 1'b0, 1'b1);
        check("irq_fall5_clr", 32'(irq), 32'h0);

        // Read and write of the same register together, upper bits dropped.
        bus_op(3'b001, 2'd1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check("rw_prewrite", rdata, 32'h021);
        bus_op(3'b001, 2'd1, 32'h0, 1'b1, 1'b0);
        check("mask_width", rdata, 32'h3FF);
        bus_op(3'b001, 2'd0, 32'h3FF, 1'b0, 1'b1);
        bus_op(3'b001, 2'd0, 32'h0, 1'b1, 1'b0);

        // Other build widths.
        bus_op(3'b010, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        bus_op(3'b010, 2'd1, 32'h0, 1'b1, 1'b0);
        check("w32_mask", rdata32, 32'hFFFF_FFFF);
        bus_op(3'b100, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        bus_op(3'b100, 2'd1, 32'h0, 1'b1, 1'b0);
        check("w1_mask", rdata1, 32'h0000_0001);
        bus_op(3'b110, 2'd3, 32'hA5A5_A5A5, 1'b0, 1'b1);
        bus_op(3'b110, 2'd3, 32'h0, 1'b1, 1'b0);
        bus_op(3'b110, 2'd0, 32'h0, 1'b1, 1'b0);

        // Randomised switch activity and bus traffic.
        for (int it = 0; it < 150; it++) begin
            sw[$urandom_range(0, W-1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) sw[$urandom_range(0, W-1)] ^= 1'b1;
            repeat ($urandom_range(1, 3 * D)) random_bus_cycle();
        end

        // All switches high, reset in the middle of the count.
        bus_op(3'b001, 2'd1, 32'h3FF, 1'b0, 1'b1);
        sw = '0;
        repeat (S + D + 2) @(negedge clk);
        sw = '1;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst2_readdata", rdata, 32'h0);
        check("rst2_irq", 32'(irq), 32'h0);
        @(negedge clk);
        bus_op(3'b001, 2'd2, 32'h0, 1'b1, 1'b0);
        check("rst2_read_held0", rdata, 32'h0);
        reset_n = 1'b1;
        repeat (12) bus_op(3'b001, 2'd0, 32'h0, 1'b1, 1'b0);
        bus_op(3'b001, 2'd0, 32'h0, 1'b1, 1'b0);
        check("rst2_data", rdata, 32'h3FF);
        bus_op(3'b001, 2'd2, 32'h0, 1'b1, 1'b0);
        check("rst2_cap", rdata, 32'h3FF);
        bus_op(3'b001, 2'd1, 32'h0, 1'b1, 1'b0);
        check("rst2_mask", rdata, 32'h000);

        repeat (3) @(negedge clk);
        check("queue_drain", 32'(exp_q.size() + exp32_q.size() + exp1_q.size()), 32'h0);
        check("aux_irq", 32'(irq32 | irq1), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
